// File: rtl/fifo_status_pkg.sv
// Shared defaults and the next-occupancy helper for the FIFO status controller.
package fifo_status_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_AF_MARGIN  = 2;
  localparam int DEF_AE_MARGIN  = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // A simultaneous push and pop leaves occupancy unchanged.
  function automatic int unsigned next_count(input int unsigned cur,
                                             input logic push_ack,
                                             input logic pop_ack);
    fifo_op_e op;
    op = fifo_op_e'({push_ack, pop_ack});
    case (op)
      OP_PUSH: return cur + 1;
      OP_POP:  return cur - 1;
      default: return cur;
    endcase
  endfunction

endpackage

// File: rtl/fifo_status_flags.sv
// Next-state full/empty/almost flags derived from next pointers and next occupancy.
module fifo_status_flags #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic [ADDR_WIDTH:0] wt_next,
  input  logic [ADDR_WIDTH:0] rd_next,
  input  logic [ADDR_WIDTH:0] count_next,
  output logic                full_next,
  output logic                empty_next,
  output logic                almost_full_next,
  output logic                almost_empty_next
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = CW'(AE_MARGIN);

  // Full means same RAM slot but one lap apart, told apart by the wrap bit.
  always_comb begin
    empty_next        = (wt_next == rd_next);
    full_next         = (wt_next[ADDR_WIDTH-1:0] == rd_next[ADDR_WIDTH-1:0]) &&
                        (wt_next[ADDR_WIDTH] != rd_next[ADDR_WIDTH]);
    almost_full_next  = (count_next >= AF_LEVEL);
    almost_empty_next = (count_next <= AE_LEVEL);
  end

endmodule

// File: rtl/fifo_status_ctrl.sv
// FIFO pointer/status controller with sticky misuse errors.
// Define FIFO_STATUS_PEAK_EN to add the peak_count high-water-mark output.
module fifo_status_ctrl
  import fifo_status_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_MARGIN  = DEF_AF_MARGIN,
  parameter int AE_MARGIN  = DEF_AE_MARGIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                err_clr,
  output logic [ADDR_WIDTH:0] wt_addr,
  output logic [ADDR_WIDTH:0] rd_addr,
  output logic                push_ack,
  output logic                pop_ack,
  output logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                push_on_full_error,
  output logic                pop_on_empty_error
`ifdef FIFO_STATUS_PEAK_EN
  ,
  output logic [ADDR_WIDTH:0] peak_count
`endif
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] wt_next, rd_next, count_next;
  logic full_next, empty_next, almost_full_next, almost_empty_next;

  assign push_ack   = push & ~full & ~rst;
  assign pop_ack    = pop & ~empty & ~rst;
  assign wt_next    = wt_addr + CW'(push_ack);
  assign rd_next    = rd_addr + CW'(pop_ack);
  assign count_next = CW'(next_count(32'(count), push_ack, pop_ack));

  fifo_status_flags #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_MARGIN  (AF_MARGIN),
    .AE_MARGIN  (AE_MARGIN)
  ) u_flags (
    .wt_next           (wt_next),
    .rd_next           (rd_next),
    .count_next        (count_next),
    .full_next         (full_next),
    .empty_next        (empty_next),
    .almost_full_next  (almost_full_next),
    .almost_empty_next (almost_empty_next)
  );

  // A rejected request sets its error even when err_clr is asserted alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_addr            <= '0;
      rd_addr            <= '0;
      count              <= '0;
      full               <= 1'b0;
      empty              <= 1'b1;
      almost_full        <= 1'b0;
      almost_empty       <= 1'b1;
      push_on_full_error <= 1'b0;
      pop_on_empty_error <= 1'b0;
    end else begin
      wt_addr      <= wt_next;
      rd_addr      <= rd_next;
      count        <= count_next;
      full         <= full_next;
      empty        <= empty_next;
      almost_full  <= almost_full_next;
      almost_empty <= almost_empty_next;
      if (push && full)
        push_on_full_error <= 1'b1;
      else if (err_clr)
        push_on_full_error <= 1'b0;
      if (pop && empty)
        pop_on_empty_error <= 1'b1;
      else if (err_clr)
        pop_on_empty_error <= 1'b0;
    end
  end

`ifdef FIFO_STATUS_PEAK_EN
  always_ff @(posedge clk) begin
    if (rst)
      peak_count <= '0;
    else if (err_clr)
      peak_count <= count_next;
    else if (count_next > peak_count)
      peak_count <= count_next;
  end
`endif

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Self-checking bench for fifo_status_ctrl against an occupancy-level reference model.
module tb_fifo_status_ctrl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
  localparam int AEM   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [AW:0] wt_addr, rd_addr, count;
  logic push_ack, pop_ack, full, empty, almost_full, almost_empty;
  logic push_on_full_error, pop_on_empty_error;
`ifdef FIFO_STATUS_PEAK_EN
  logic [AW:0] peak_count;
`endif

  fifo_status_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM), .AE_MARGIN(AEM)) dut (
    .clk                (clk),
    .rst                (rst),
    .push               (push),
    .pop                (pop),
    .err_clr            (err_clr),
    .wt_addr            (wt_addr),
    .rd_addr            (rd_addr),
    .push_ack           (push_ack),
    .pop_ack            (pop_ack),
    .count              (count),
    .full               (full),
    .empty              (empty),
    .almost_full        (almost_full),
    .almost_empty       (almost_empty),
    .push_on_full_error (push_on_full_error),
    .pop_on_empty_error (pop_on_empty_error)
`ifdef FIFO_STATUS_PEAK_EN
    ,
    .peak_count         (peak_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: occupancy and total-transfer counts, no pointer encoding.
  int occ = 0, n_in = 0, n_out = 0, peak = 0;
  bit pfe = 0, pee = 0;
  logic [1:0] obs_acks, exp_acks;

  wire [5:0] dut_flags = {full, empty, almost_full, almost_empty,
                          push_on_full_error, pop_on_empty_error};

  function automatic logic [5:0] exp_flags();
    return {occ == DEPTH, occ == 0, occ >= DEPTH - AFM, occ <= AEM, pfe, pee};
  endfunction

  // Drive one cycle, record acks just after inputs settle, advance the model.
  task automatic drive_cycle(input logic p, input logic q, input logic c, input logic r);
    bit pa, qa;
    @(negedge clk);
    push = p; pop = q; err_clr = c; rst = r;
    #1;
    pa = !r && p && occ < DEPTH;
    qa = !r && q && occ > 0;
    obs_acks = {push_ack, pop_ack};
    exp_acks = {pa, qa};
    @(posedge clk);
    if (r) begin
      occ = 0; n_in = 0; n_out = 0; peak = 0; pfe = 0; pee = 0;
    end else begin
      if (p && !pa) pfe = 1; else if (c) pfe = 0;
      if (q && !qa) pee = 1; else if (c) pee = 0;
      occ   = occ + int'(pa) - int'(qa);
      n_in  = n_in + int'(pa);
      n_out = n_out + int'(qa);
      if (c || occ > peak) peak = occ;
    end
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1, 1, 0, 1);
    n_checks++;
    if (obs_acks !== 2'b00) begin
      n_fail++; $display("[TB] FAIL reset_acks got=%b exp=00", obs_acks);
    end
    drive_cycle(0, 0, 0, 0);
    n_checks++;
    if ({wt_addr, rd_addr, count} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_ptrs got wt=%h rd=%h cnt=%0d exp 0", wt_addr, rd_addr, count);
    end
    n_checks++;
    if (dut_flags !== 6'b010100) begin
      n_fail++; $display("[TB] FAIL reset_flags got=%b exp=010100", dut_flags);
    end
  endtask

  task automatic test_fill();
    int af_first = -1;
    for (int i = 1; i <= DEPTH; i++) begin
      drive_cycle(1, 0, 0, 0);
      if (almost_full && af_first < 0) af_first = int'(count);
      n_checks++;
      if (count !== PW'(i) || dut_flags !== exp_flags()) begin
        n_fail++; $display("[TB] FAIL fill_step%0d got cnt=%0d flags=%b exp cnt=%0d flags=%b",
                           i, count, dut_flags, i, exp_flags());
      end
    end
    n_checks++;
    if (af_first !== DEPTH - AFM) begin
      n_fail++; $display("[TB] FAIL fill_af_first got=%0d exp=%0d", af_first, DEPTH - AFM);
    end
    n_checks++;
    if (wt_addr !== 5'b1_0000 || full !== 1'b1) begin
      n_fail++; $display("[TB] FAIL fill_full got wt=%b full=%b exp wt=10000 full=1", wt_addr, full);
    end
    drive_cycle(1, 0, 0, 0);
    n_checks++;
    if (obs_acks !== 2'b00 || push_on_full_error !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("[TB] FAIL overflow got acks=%b err=%b cnt=%0d exp acks=00 err=1 cnt=16",
                         obs_acks, push_on_full_error, count);
    end
  endtask

  // Entered full with push_on_full_error already set; err_clr alongside a rejected push must lose.
  task automatic test_full_push_pop();
    drive_cycle(1, 1, 1, 0);
    n_checks++;
    if (obs_acks !== 2'b01) begin
      n_fail++; $display("[TB] FAIL full_pp_acks got=%b exp=01", obs_acks);
    end
    n_checks++;
    if (rd_addr !== 5'd1 || wt_addr !== 5'b1_0000 || count !== 5'd15 || push_on_full_error !== 1'b1) begin
      n_fail++; $display("[TB] FAIL full_pp got rd=%b wt=%b cnt=%0d err=%b exp rd=00001 wt=10000 cnt=15 err=1",
                         rd_addr, wt_addr, count, push_on_full_error);
    end
    n_checks++;
    if (dut_flags !== exp_flags()) begin
      n_fail++; $display("[TB] FAIL full_pp_flags got=%b exp=%b", dut_flags, exp_flags());
    end
  endtask

  task automatic test_empty_pop();
    drive_cycle(0, 0, 0, 1);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 0, 0);
    n_checks++;
    if (wt_addr !== 5'd1 || rd_addr !== 5'd1 || empty !== 1'b1) begin
      n_fail++; $display("[TB] FAIL empty_setup got wt=%b rd=%b empty=%b exp 00001/00001/1", wt_addr, rd_addr, empty);
    end
    drive_cycle(0, 1, 0, 0);
    n_checks++;
    if (obs_acks[0] !== 1'b0 || pop_on_empty_error !== 1'b1) begin
      n_fail++; $display("[TB] FAIL underflow got pop_ack=%b err=%b exp 0/1", obs_acks[0], pop_on_empty_error);
    end
    drive_cycle(0, 0, 1, 0);
    n_checks++;
    if (pop_on_empty_error !== 1'b0) begin
      n_fail++; $display("[TB] FAIL err_clr got=%b exp=0", pop_on_empty_error);
    end
    drive_cycle(1, 1, 0, 0);
    n_checks++;
    if (obs_acks !== 2'b10 || count !== 5'd1 || pop_on_empty_error !== 1'b1) begin
      n_fail++; $display("[TB] FAIL empty_pp got acks=%b cnt=%0d err=%b exp acks=10 cnt=1 err=1",
                         obs_acks, count, pop_on_empty_error);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] start_flags;
    drive_cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 0);
    start_flags = dut_flags;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1, 1, 0, 0);
      n_checks++;
      if (count !== 5'd3 || dut_flags !== start_flags || dut_flags !== exp_flags()) begin
        n_fail++; $display("[TB] FAIL wrap_step%0d got cnt=%0d flags=%b exp cnt=3 flags=%b",
                           i, count, dut_flags, exp_flags());
      end
    end
    n_checks++;
    if (wt_addr !== PW'(43) || rd_addr !== PW'(40)) begin
      n_fail++; $display("[TB] FAIL wrap_ptrs got wt=%0d rd=%0d exp wt=11 rd=8", wt_addr, rd_addr);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 0, 0);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    n_checks++;
    if (count !== 5'd9) begin
      n_fail++; $display("[TB] FAIL mid_setup got cnt=%0d exp=9", count);
    end
    drive_cycle(1, 0, 0, 1);
    n_checks++;
    if (obs_acks !== 2'b00 || {wt_addr, rd_addr, count} !== '0 || dut_flags !== 6'b010100) begin
      n_fail++; $display("[TB] FAIL mid_reset got acks=%b wt=%0d rd=%0d cnt=%0d flags=%b exp all reset",
                         obs_acks, wt_addr, rd_addr, count, dut_flags);
    end
`ifdef FIFO_STATUS_PEAK_EN
    n_checks++;
    if (peak_count !== '0) begin
      n_fail++; $display("[TB] FAIL mid_peak got=%0d exp=0", peak_count);
    end
`endif
  endtask

  task automatic test_random();
    bit p, q, c, r;
    int bias;
    for (int i = 0; i < 600; i++) begin
      bias = (i % 200 < 100) ? 75 : 25;
      p = $urandom_range(0, 99) < bias;
      q = $urandom_range(0, 99) < 100 - bias;
      c = $urandom_range(0, 19) == 0;
      r = $urandom_range(0, 249) == 0;
      drive_cycle(p, q, c, r);
      n_checks++;
      if (obs_acks !== exp_acks) begin
        n_fail++; $display("[TB] FAIL rand_acks cyc=%0d got=%b exp=%b", i, obs_acks, exp_acks);
      end
      n_checks++;
      if (wt_addr !== PW'(n_in % 32) || rd_addr !== PW'(n_out % 32) || count !== PW'(occ)) begin
        n_fail++; $display("[TB] FAIL rand_ptrs cyc=%0d got wt=%0d rd=%0d cnt=%0d exp wt=%0d rd=%0d cnt=%0d",
                           i, wt_addr, rd_addr, count, n_in % 32, n_out % 32, occ);
      end
      n_checks++;
      if (dut_flags !== exp_flags()) begin
        n_fail++; $display("[TB] FAIL rand_flags cyc=%0d got=%b exp=%b", i, dut_flags, exp_flags());
      end
`ifdef FIFO_STATUS_PEAK_EN
      n_checks++;
      if (peak_count !== PW'(peak)) begin
        n_fail++; $display("[TB] FAIL rand_peak cyc=%0d got=%0d exp=%0d", i, peak_count, peak);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_push_pop();
    test_empty_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_status_ctrl.md
FIFO_STATUS_CTRL -- requirements
Module: fifo_status_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, RAM address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 Parameter AF_MARGIN, default 2, almost-full distance from DEPTH.
REQ-003 Parameter AE_MARGIN, default 2, almost-empty occupancy threshold.
REQ-004 The clock and reset SHALL be: one clock, clk, rising edge; reset is synchronous and active-high, rst.
REQ-005 clk  in  1  sole clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 push  in  1  write request.
REQ-008 pop  in  1  read request.
REQ-009 err_clr  in  1  clears sticky error flags.
REQ-010 wt_addr  out  ADDR_WIDTH+1  write pointer; MSB is wrap bit, low bits address RAM.
REQ-011 rd_addr  out  ADDR_WIDTH+1  read pointer; same format.
REQ-012 push_ack / pop_ack  out  1 each  request accepted this cycle (combinational).
REQ-013 count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
REQ-014 full, empty, almost_full, almost_empty  out  1 each  registered status.
REQ-015 push_on_full_error, pop_on_empty_error  out  1 each  sticky errors.

Function
REQ-016 push_ack SHALL equal push & !full; pop_ack SHALL equal pop & !empty; both may assert in one cycle.
REQ-017 On push_ack, wt_addr SHALL increment by 1 modulo 2**(ADDR_WIDTH+1); on pop_ack, rd_addr likewise.
REQ-018 count SHALL update at the same edge: +1 push_ack only, -1 pop_ack only, unchanged for both or neither.
REQ-019 empty SHALL be 1 iff wt_addr == rd_addr (all bits).
REQ-020 full SHALL be 1 iff low bits equal and MSBs differ; count SHALL then be DEPTH.
REQ-021 almost_full SHALL be 1 iff count >= DEPTH-AF_MARGIN; almost_empty iff count <= AE_MARGIN.
REQ-022 All status outputs SHALL reflect post-edge state in the cycle after the edge; no combinational path from push/pop to status.
REQ-023 Full with push and pop: pop accepted, push rejected, push_on_full_error set; count becomes DEPTH-1.
REQ-024 Empty with push and pop: push accepted, pop rejected, pop_on_empty_error set; count becomes 1.
REQ-025 Error flags SHALL set at the edge after the rejected request and hold until err_clr or rst; a set in the same cycle as err_clr SHALL win.
REQ-026 Pointer wrap past 2**(ADDR_WIDTH+1)-1 to 0 SHALL not disturb full/empty/count.

Reset
REQ-027 rst SHALL, at the next clk edge, override push/pop and force wt_addr=0, rd_addr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, both errors=0.
REQ-028 rst mid-operation SHALL discard all contents; push_ack/pop_ack SHALL be 0 while rst=1.

Configuration
REQ-029 Macro FIFO_STATUS_PEAK_EN defined: extra output peak_count (ADDR_WIDTH+1) SHALL hold the maximum count since reset/err_clr, updated at the same edge as count.
REQ-030 Macro undefined: peak_count port and logic SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package fifo_status_pkg SHALL hold default ADDR_WIDTH/AF_MARGIN/AE_MARGIN constants and a function computing next count from push_ack/pop_ack.
REQ-032 Sub-module fifo_status_flags SHALL compute next-state full/empty/almost flags from next pointers and next count; fifo_status_ctrl registers them.

Verification (ADDR_WIDTH=4, DEPTH=16, margins 2)
REQ-033 Reset then idle -> pointers 0, count 0, empty=1, almost_empty=1, others 0.
REQ-034 16 consecutive pushes -> wt_addr=5'b1_0000, count=16, full=1; almost_full first at count 14; a 17th push -> push_ack=0, push_on_full_error=1.
REQ-035 Full, push+pop together -> rd_addr=1, wt_addr unchanged, count=15, push_on_full_error=1.
REQ-036 Empty at rd=wt=5'b0_0001, pop -> pop_ack=0, pop_on_empty_error=1; err_clr next cycle -> 0.
REQ-037 Run 40 push/pop pairs from count 3 -> pointers wrap past 5'b1_1111, count stays 3, no flags change.
REQ-038 rst asserted with count=9 and push=1 -> next cycle all REQ-027 values; peak_count (macro on) 0.
